// File: rtl/quad_decoder_param.sv
// rtl/quad_decoder_param.sv - parametrised 4x quadrature decoder
// Synchronises and glitch-filters A/B, then decodes Gray steps into a signed count.
module quad_decoder_param #(
  parameter int CNT_W        = 10,
  parameter int SYNC_STAGES  = 2,
  parameter int FILT_LEN     = 4,
  parameter int DETENT_SHIFT = 2,
  parameter int SATURATE     = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enc_a,
  input  logic                          enc_b,
  input  logic                          clear,
  input  logic                          load,
  input  logic [CNT_W-1:0]              load_val,
  output logic [CNT_W-1:0]              count,
  output logic [CNT_W-DETENT_SHIFT-1:0] detent,
  output logic                          dir,
  output logic                          step_up,
  output logic                          step_dn,
  output logic                          err,
  output logic                          primed
);

  localparam int FCW     = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int PRIME_N = SYNC_STAGES + FILT_LEN;
  localparam int PCW     = $clog2(PRIME_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MIN = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Channel index 1 is A, 0 is B, so flt_q reads as {a_f, b_f}.
  logic [1:0]                  raw;
  logic [1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0]                  flt_q, flt_d;
  logic [1:0][FCW-1:0]         fcnt_q, fcnt_d;
  logic [1:0]                  prev_q, prev_d;
  logic [PCW-1:0]              prime_cnt_q, prime_cnt_d;
  logic                        primed_q, primed_d;
  logic [CNT_W-1:0]            count_q, count_d, count_step;
  logic                        dir_q, dir_d;
  logic                        step_up_q, step_up_d;
  logic                        step_dn_q, step_dn_d;
  logic                        err_q, err_d;
  logic                        is_up, is_dn, is_bad;
  logic signed [CNT_W-1:0]     count_shr;

  assign raw = {enc_a, enc_b};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], raw[i]};
      flt_d[i]  = flt_q[i];
      fcnt_d[i] = '0;
      if (sync_q[i][SYNC_STAGES-1] != flt_q[i]) begin
        if (fcnt_q[i] == FCW'(FILT_LEN - 1)) flt_d[i] = sync_q[i][SYNC_STAGES-1];
        else fcnt_d[i] = fcnt_q[i] + FCW'(1);
      end
    end
  end

  always_comb begin
    prime_cnt_d = prime_cnt_q;
    primed_d    = primed_q;
    if (!primed_q) begin
      prime_cnt_d = prime_cnt_q + PCW'(1);
      if (prime_cnt_q == PCW'(PRIME_N - 1)) primed_d = 1'b1;
    end
    // While priming, prev follows the value the filter is about to settle on,
    // so the first settled state is seen as "no change" rather than a step.
    prev_d = primed_q ? flt_q : flt_d;
  end

  always_comb begin
    is_up  = 1'b0;
    is_dn  = 1'b0;
    is_bad = 1'b0;
    if (primed_q) begin
      case ({prev_q, flt_q})
        4'b0010, 4'b1011, 4'b1101, 4'b0100: is_up  = 1'b1;
        4'b1000, 4'b1110, 4'b0111, 4'b0001: is_dn  = 1'b1;
        4'b0011, 4'b1100, 4'b1001, 4'b0110: is_bad = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    count_step = count_q;
    if (is_up && !(SATURATE != 0 && count_q == CNT_MAX)) count_step = count_q + CNT_ONE;
    else if (is_dn && !(SATURATE != 0 && count_q == CNT_MIN)) count_step = count_q - CNT_ONE;

    if (clear)     count_d = '0;
    else if (load) count_d = load_val;
    else           count_d = count_step;

    err_d     = is_bad | (err_q & ~clear);
    dir_d     = is_up ? 1'b1 : (is_dn ? 1'b0 : dir_q);
    step_up_d = is_up;
    step_dn_d = is_dn;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q      <= '0;
      flt_q       <= '0;
      fcnt_q      <= '0;
      prev_q      <= '0;
      prime_cnt_q <= '0;
      primed_q    <= 1'b0;
      count_q     <= '0;
      dir_q       <= 1'b0;
      step_up_q   <= 1'b0;
      step_dn_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      flt_q       <= flt_d;
      fcnt_q      <= fcnt_d;
      prev_q      <= prev_d;
      prime_cnt_q <= prime_cnt_d;
      primed_q    <= primed_d;
      count_q     <= count_d;
      dir_q       <= dir_d;
      step_up_q   <= step_up_d;
      step_dn_q   <= step_dn_d;
      err_q       <= err_d;
    end
  end

  assign count_shr = $signed(count_q) >>> DETENT_SHIFT;
  assign detent    = count_shr[CNT_W-DETENT_SHIFT-1:0];
  assign count     = count_q;
  assign dir       = dir_q;
  assign step_up   = step_up_q;
  assign step_dn   = step_dn_q;
  assign err       = err_q;
  assign primed    = primed_q;

endmodule

// File: tb/tb_quad_decoder_param.sv
// tb/tb_quad_decoder_param.sv - scoreboard bench for quad_decoder_param
// Three instances share A/B: default, 4-bit wrapping and 4-bit saturating.
module tb_quad_decoder_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, enc_a, enc_b, clear, load;
  logic [9:0] lv10;
  logic [3:0] lv4;

  logic [9:0] c10;  logic [7:0] d10;
  logic [3:0] c4w;  logic [1:0] d4w;
  logic [3:0] c4s;  logic [1:0] d4s;
  logic dir10, up10, dn10, err10, pr10;
  logic dir4w, up4w, dn4w, err4w, pr4w;
  logic dir4s, up4s, dn4s, err4s, pr4s;

  quad_decoder_param u10 (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .clear(clear), .load(load),
    .load_val(lv10), .count(c10), .detent(d10), .dir(dir10), .step_up(up10),
    .step_dn(dn10), .err(err10), .primed(pr10));

  quad_decoder_param #(.CNT_W(4), .SATURATE(0)) u4w (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .clear(clear), .load(load),
    .load_val(lv4), .count(c4w), .detent(d4w), .dir(dir4w), .step_up(up4w),
    .step_dn(dn4w), .err(err4w), .primed(pr4w));

  quad_decoder_param #(.CNT_W(4), .SATURATE(1)) u4s (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .clear(clear), .load(load),
    .load_val(lv4), .count(c4s), .detent(d4s), .dir(dir4s), .step_up(up4s),
    .step_dn(dn4s), .err(err4s), .primed(pr4s));

  typedef struct {
    int stamp;
    int c10;
    int c4w;
    int c4s;
    bit up;
    bit dn;
    bit er;
    bit dr;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   cyc = 0;
  int   n_pass = 0, n_total = 0, n_up = 0, n_dn = 0;
  int   m10 = 0, m4w = 0, m4s = 0;
  bit   m_err = 0, m_dir = 0;
  bit   err_prev = 0;
  logic [1:0] cur_ab = 2'b00;
  logic [1:0] gray [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int gidx(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int wrapw(input int x, input int w);
    int m = 1 << w;
    int h = 1 << (w - 1);
    int r = (x + h) % m;
    if (r < 0) r += m;
    return r - h;
  endfunction

  function automatic int clampw(input int x, input int w);
    int hi = (1 << (w - 1)) - 1;
    int lo = -(1 << (w - 1));
    return (x > hi) ? hi : ((x < lo) ? lo : x);
  endfunction

  function automatic int floor4(input int x);
    return (x >= 0) ? x / 4 : -((-x + 3) / 4);
  endfunction

  // Drive a new A/B state; when tracked, the model judges the step from Gray positions.
  task automatic move(input logic [1:0] ab, input int hold, input bit track);
    exp_t e;
    int d;
    @(posedge clk); #1;
    if (track && ab != cur_ab) begin
      d = (gidx(ab) - gidx(cur_ab) + 4) % 4;
      e.stamp = cyc;
      e.up = (d == 1);
      e.dn = (d == 3);
      if (d == 2) m_err = 1;
      else begin
        m10   = wrapw(m10 + ((d == 1) ? 1 : -1), 10);
        m4w   = wrapw(m4w + ((d == 1) ? 1 : -1), 4);
        m4s   = clampw(m4s + ((d == 1) ? 1 : -1), 4);
        m_dir = (d == 1);
      end
      e.c10 = m10; e.c4w = m4w; e.c4s = m4s; e.er = m_err; e.dr = m_dir;
      q.push_back(e);
    end
    enc_a = ab[1];
    enc_b = ab[0];
    if (track) cur_ab = ab;
    repeat (hold - 1) @(posedge clk);
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 40) begin
      @(posedge clk);
      t++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic do_load(input bit ld, input bit cl, input int v10, input int v4);
    @(posedge clk); #1;
    lv10 = v10[9:0];
    lv4  = v4[3:0];
    load = ld;
    clear = cl;
    @(posedge clk); #1;
    load = 0;
    clear = 0;
    if (cl) begin
      m10 = 0; m4w = 0; m4s = 0; m_err = 0;
    end else if (ld) begin
      m10 = wrapw(v10, 10); m4w = wrapw(v4, 4); m4s = m4w;
    end
    @(negedge clk);
    chk("ld_count10", $signed(c10), m10);
    chk("ld_count4w", $signed(c4w), m4w);
    chk("ld_count4s", $signed(c4s), m4s);
    chk("ld_err", err10, m_err);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_count"}, $signed(c10), 0);
    chk({tag, "_detent"}, $signed(d10), 0);
    chk({tag, "_dir"}, dir10, 0);
    chk({tag, "_up"}, up10, 0);
    chk({tag, "_dn"}, dn10, 0);
    chk({tag, "_err"}, err10, 0);
    chk({tag, "_primed"}, pr10, 0);
    chk({tag, "_count4w"}, $signed(c4w), 0);
  endtask

  task automatic release_and_prime(input string tag);
    @(posedge clk); #1;
    reset = 0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk({tag, "_primed_at5"}, pr10, 0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_primed_at6"}, pr10, 1);
  endtask

  always @(negedge clk) begin
    if (up10 || dn10 || (err10 && !err_prev)) begin
      n_up += int'(up10);
      n_dn += int'(dn10);
      if (q.size() == 0) chk("unexpected_event", q.size(), 1);
      else begin
        me = q.pop_front();
        chk("latency", cyc, me.stamp + 7);
        chk("count10", $signed(c10), me.c10);
        chk("detent10", $signed(d10), floor4(me.c10));
        chk("count4w", $signed(c4w), me.c4w);
        chk("count4s", $signed(c4s), me.c4s);
        chk("step_up", up10, me.up);
        chk("step_dn", dn10, me.dn);
        chk("step_up4s", up4s, me.up);
        chk("dir", dir10, me.dr);
        chk("err", err10, me.er);
      end
    end
    err_prev = err10;
  end

  initial begin
    int u0, d0;
    logic [1:0] nxt;
    reset = 1; enc_a = 0; enc_b = 0; clear = 0; load = 0; lv10 = '0; lv4 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("rst");
    release_and_prime("rst");
    repeat (4) @(posedge clk);

    u0 = n_up;
    for (int i = 0; i < 8; i++) begin
      move(2'b10, 10, 1); move(2'b11, 10, 1); move(2'b01, 10, 1); move(2'b00, 10, 1);
    end
    drain();
    chk("up32_count", $signed(c10), 32);
    chk("up32_detent", $signed(d10), 8);
    chk("up32_dir", dir10, 1);
    chk("up32_pulses", n_up - u0, 32);
    chk("up32_err", err10, 0);

    d0 = n_dn;
    for (int i = 0; i < 3; i++) begin
      move(2'b01, 10, 1); move(2'b11, 10, 1); move(2'b10, 10, 1); move(2'b00, 10, 1);
    end
    drain();
    chk("dn12_count", $signed(c10), 20);
    chk("dn12_detent", $signed(d10), 5);
    chk("dn12_dir", dir10, 0);
    chk("dn12_pulses", n_dn - d0, 12);

    u0 = n_up;
    move(2'b10, 3, 0);
    move(2'b00, 15, 0);
    @(negedge clk);
    chk("glitch3_count", $signed(c10), 20);
    chk("glitch3_pulses", n_up - u0, 0);
    move(2'b10, 4, 1);
    move(2'b01, 12, 1);
    drain();
    chk("glitch4_count", $signed(c10), 21);
    chk("illegal_err", err10, 1);
    do_load(0, 1, 0, 0);

    do_load(1, 0, int'($urandom_range(0, 1023)), 7);
    move(gray[(gidx(cur_ab) + 1) % 4], 10, 1);
    drain();
    chk("wrap4_count", $signed(c4w), -8);
    chk("sat4_count", $signed(c4s), 7);
    do_load(1, 1, 100, 3);

    for (int i = 0; i < 80; i++) begin
      if (i % 16 == 15) begin
        drain();
        do_load(1, 0, int'($urandom_range(0, 1023)), int'($urandom_range(0, 15)));
      end
      nxt = ($urandom_range(0, 1) == 1) ? gray[(gidx(cur_ab) + 1) % 4]
                                        : gray[(gidx(cur_ab) + 3) % 4];
      move(nxt, int'($urandom_range(4, 12)), 1);
    end
    drain();

    if (cur_ab == 2'b11) move(2'b01, 10, 1);
    while (gray[(gidx(cur_ab) + 1) % 4] != 2'b11) move(gray[(gidx(cur_ab) + 1) % 4], 10, 1);
    move(2'b11, 3, 1);
    @(posedge clk); #1;
    reset = 1;
    q.delete();
    m10 = 0; m4w = 0; m4s = 0; m_err = 0; m_dir = 0;
    u0 = n_up;
    d0 = n_dn;
    @(negedge clk);
    check_reset_state("midrst");
    repeat (2) @(posedge clk);
    release_and_prime("midrst");
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("post_rst_count", $signed(c10), 0);
    chk("post_rst_err", err10, 0);
    chk("post_rst_pulses", (n_up - u0) + (n_dn - d0), 0);
    move(gray[(gidx(cur_ab) + 3) % 4], 10, 1);
    drain();
    chk("post_rst_step", $signed(c10), -1);
    chk("queue_empty_end", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
